csa_accum_nbit: RTL and testbench
=================================

Name: csa_accum_nbit

Overview:
- Parametrised, sequential partial-product accumulator for the Vedic multiplier datapath.
- Generalises the fixed 8-bit + 5-bit single-shot carry-save adder stage:
  - accepts a stream of OP_W-bit partial products, each with a left-shift weight;
  - sums them into an ACC_W-bit accumulator;
  - returns the total over a valid/ready handshake.
- Adds wrap or saturate overflow mode, a sticky overflow flag and a beat count.

Parameters:
- ACC_W, 8: accumulator and result width.
- OP_W, 5: partial-product operand width.
- SH_W, 2: shift-amount width; maximum left shift is 2^SH_W-1.
- CNT_W, 4: beat-counter width.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_op  input  OP_W  partial-product operand, unsigned.
- in_shift  input  SH_W  left-shift weight applied to in_op.
- in_first  input  1  beat starts a new sum.
- in_last  input  1  beat ends the sum.
- sat_mode  input  1  1 = saturate, 0 = wrap; sampled on the starting beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated result.
- out_ovf  output  1  sticky overflow flag for this sum.
- out_beats  output  CNT_W  number of beats accepted in this sum; saturates at 2^CNT_W-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE;
  - accumulator, out_sum, out_ovf, out_beats, out_valid and the latched mode all clear to 0;
  - in_ready = 1 after reset deasserts.
  - Asserting reset mid-sum discards all partial state; no result is emitted.
- Accept condition: a beat is accepted when in_valid && in_ready at a clk rising edge.
- Addend computation:
  - addend = zero-extended in_op << in_shift;
  - computed at width ACC_W + OP_W + 2^SH_W, so no addend bits are lost before the overflow check.
- Accumulate rule, evaluated at full width:
  - sum = (start ? 0 : acc) + addend;
  - if sum >= 2^ACC_W, out_ovf is set and stays set until the next start;
  - wrap mode: acc = sum mod 2^ACC_W (truncation, same behaviour as a discarded top carry);
  - saturate mode: acc = all ones, and acc stays all ones for the rest of the sum.
- States:
  - IDLE:
    - in_ready = 1, out_valid = 0.
    - Any accepted beat is a start, whether or not in_first is set.
    - On a start: latch sat_mode, clear ovf, set beats = 1.
    - If in_last is also set, go to HOLD; otherwise go to ACCUM.
  - ACCUM:
    - in_ready = 1.
    - Accepted beat with in_first = 1: restart. Previous partial sum, ovf and beats are discarded, and sat_mode is re-latched.
    - Accepted beat with in_first = 0: accumulate and increment beats.
    - in_last on the accepted beat: go to HOLD.
    - No accepted beat: hold all state.
  - HOLD:
    - in_ready = 0, out_valid = 1.
    - out_sum, out_ovf and out_beats are stable and registered.
    - out_ready = 1: return to IDLE, and out_valid drops on the next cycle.
- Latency:
  - out_valid rises on the cycle after the last beat is accepted.
  - Throughput is one beat per cycle.
  - HOLD costs at least one bubble cycle per sum; there is no pass-through from result to next input.
- Boundary conditions:
  - in_first and in_last on the same beat: single-beat sum, result = addend with the overflow rule applied.
  - out_beats saturates at its maximum and does not wrap.
  - Input signals are ignored while in_ready = 0.
  - sat_mode changing mid-sum has no effect.
- Output registers: all outputs are registers except in_ready, which is decoded from state.

Test Plan:
- Default parameters; single beat in_op=0x1F, in_shift=0, first+last -> one cycle later out_valid=1, out_sum=0x1F, out_ovf=0, out_beats=1.
- Wrap mode, beats (0x1F, shift 3) then (0x10, shift 0, last); true sum 0x108 -> out_sum=0x08, out_ovf=1, out_beats=2.
- Saturate mode, same beats -> out_sum=0xFF, out_ovf=1. A further third beat (0x01) before last leaves out_sum=0xFF.
- Backpressure: out_ready held low 3 cycles in HOLD -> out_valid=1, in_ready=0 and outputs unchanged throughout. On out_ready=1, IDLE follows and in_ready returns to 1 the next cycle.
- Restart: beats 0x05, 0x03, then in_first beat 0x02 with last -> out_sum=0x02, out_beats=1, out_ovf=0.
- Reset mid-sum: rst_n low for 1 cycle in ACCUM with acc=0x40 -> all outputs 0 immediately. A subsequent beat 0x01 with last -> out_sum=0x01.

Source files
------------

// File: rtl/csa_accum_nbit.sv
// Sequential carry-save partial-product accumulator: sums shifted OP_W-bit operands
// into an ACC_W-bit total with wrap/saturate overflow, sticky overflow flag and beat count.
module csa_accum_nbit #(
  parameter int ACC_W = 8,
  parameter int OP_W  = 5,
  parameter int SH_W  = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [SH_W-1:0]  in_shift,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             sat_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_beats
);

  // Wide enough that neither the shifted addend nor acc + addend can lose a bit.
  localparam int FW = ACC_W + OP_W + (1 << SH_W);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [CNT_W-1:0]   beats;
  logic               mode_q;

  logic               accept;
  logic               start;
  logic               mode_eff;
  logic               ovf_now;
  logic [FW-1:0]      addend;
  logic [FW-1:0]      sum;
  logic [ACC_W-1:0]   acc_nxt;
  logic               ovf_nxt;
  logic [CNT_W-1:0]   beats_nxt;

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  // In IDLE every accepted beat opens a new sum; in ACCUM only an in_first beat does.
  assign start    = accept && ((state == IDLE) || in_first);

  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    addend    = {{(FW-OP_W){1'b0}}, in_op} << in_shift;
    sum       = (start ? {FW{1'b0}} : {{(FW-ACC_W){1'b0}}, acc}) + addend;
    mode_eff  = start ? sat_mode : mode_q;
    ovf_now   = |sum[FW-1:ACC_W];
    acc_nxt   = (ovf_now && mode_eff) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    ovf_nxt   = (ovf && !start) || ovf_now;
    if (start)
      beats_nxt = CNT_W'(1);
    else if (&beats)
      beats_nxt = beats;
    else
      beats_nxt = beats + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      beats     <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc    <= acc_nxt;
            ovf    <= ovf_nxt;
            beats  <= beats_nxt;
            mode_q <= mode_eff;
            if (in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
              out_ovf   <= ovf_nxt;
              out_beats <= beats_nxt;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_nbit.sv
// Self-checking bench for csa_accum_nbit: directed scenarios plus randomized sums
// checked against an integer-arithmetic model of the accumulate/overflow rules.
module tb_csa_accum_nbit;

  localparam int ACC_W = 8;
  localparam int OP_W  = 5;
  localparam int SH_W  = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [SH_W-1:0]  in_shift;
  logic             in_first;
  logic             in_last;
  logic             sat_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_beats;

  csa_accum_nbit #(.ACC_W(ACC_W), .OP_W(OP_W), .SH_W(SH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_shift(in_shift),
    .in_first(in_first), .in_last(in_last), .sat_mode(sat_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the running sum of the current transaction.
  longint m_acc;
  bit     m_ovf;
  int     m_beats;
  bit     m_mode;
  bit     m_active;

  task automatic check(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_beat(input int op, input int sh, input bit first, input bit mode);
    longint s;
    bit st;
    st = !m_active || first;
    if (st) begin
      m_acc = 0; m_ovf = 0; m_beats = 0; m_mode = mode;
    end
    s = m_acc + (longint'(op) << sh);
    if (s >= (longint'(1) << ACC_W)) begin
      m_ovf = 1;
      m_acc = m_mode ? (longint'(1) << ACC_W) - 1 : s % (longint'(1) << ACC_W);
    end else begin
      m_acc = s;
    end
    if (m_beats < (1 << CNT_W) - 1) m_beats++;
    m_active = 1;
  endtask

  task automatic send_beat(input int op, input int sh, input bit first, input bit last, input bit mode);
    @(negedge clk);
    check("ready_before_beat", in_ready, 1);
    in_valid = 1'b1;
    in_op    = OP_W'(op);
    in_shift = SH_W'(sh);
    in_first = first;
    in_last  = last;
    sat_mode = mode;
    @(posedge clk);
    model_beat(op, sh, first, mode);
    if (last) m_active = 0;
  endtask

  task automatic gap_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = OP_W'($urandom);
    in_first = 1'($urandom);
    in_last  = 1'($urandom);
    sat_mode = 1'($urandom);
    @(posedge clk);
  endtask

  // Junk on the inputs while in HOLD must be ignored.
  task automatic drive_junk();
    in_valid = 1'($urandom);
    in_op    = OP_W'($urandom);
    in_shift = SH_W'($urandom);
    in_first = 1'($urandom);
    in_last  = 1'($urandom);
    sat_mode = 1'($urandom);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_sum"}, out_sum, m_acc);
    check({tag, "_ovf"}, out_ovf, m_ovf);
    check({tag, "_beats"}, out_beats, m_beats);
  endtask

  task automatic expect_result(input string tag, input int hold);
    @(negedge clk);
    drive_junk();
    out_ready = 1'b0;
    check_result(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      drive_junk();
      check_result({tag, "_hold"});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_shift = '0;
    in_first = 1'b0; in_last = 1'b0; sat_mode = 1'b0; out_ready = 1'b0;
    m_acc = 0; m_ovf = 0; m_beats = 0; m_mode = 0; m_active = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_beats", out_beats, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);

    // Single beat, first+last.
    send_beat(5'h1F, 0, 1, 1, 0);
    check("single_exp_sum", m_acc, 'h1F);
    expect_result("single", 0);

    // Wrap overflow: 0xF8 + 0x10 = 0x108.
    send_beat(5'h1F, 3, 1, 0, 0);
    send_beat(5'h10, 0, 0, 1, 1);
    check("wrap_exp_sum", m_acc, 'h08);
    expect_result("wrap", 0);

    // Saturate, then a further beat keeps all ones.
    send_beat(5'h1F, 3, 1, 0, 1);
    send_beat(5'h10, 0, 0, 0, 0);
    send_beat(5'h01, 0, 0, 1, 0);
    check("sat_exp_sum", m_acc, 'hFF);
    expect_result("sat", 0);

    // Backpressure: out_ready low for 3 cycles in HOLD.
    send_beat(5'h07, 2, 1, 0, 0);
    send_beat(5'h03, 1, 0, 1, 0);
    expect_result("bp", 3);

    // Restart mid-sum discards partial state.
    send_beat(5'h05, 0, 1, 0, 0);
    send_beat(5'h03, 0, 0, 0, 1);
    send_beat(5'h02, 0, 1, 1, 0);
    check("restart_exp_sum", m_acc, 'h02);
    expect_result("restart", 0);

    // Asynchronous reset mid-sum with acc = 0x40.
    send_beat(5'h10, 2, 1, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", out_sum, 0);
    check("midrst_ovf", out_ovf, 0);
    check("midrst_beats", out_beats, 0);
    check("midrst_ready", in_ready, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    m_active = 0;
    send_beat(5'h01, 0, 0, 1, 0);
    expect_result("after_rst", 0);

    // Randomized sums: restarts, gaps, long sums for beat saturation, random backpressure.
    for (int t = 0; t < 60; t++) begin
      int len;
      len = $urandom_range(1, 19);
      for (int i = 0; i < len; i++) begin
        int op;
        bit first;
        op = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
        first = (i == 0) ? 1'($urandom) : ($urandom_range(0, 11) == 0);
        if (i != 0 && $urandom_range(0, 4) == 0) gap_cycle();
        send_beat(op, $urandom_range(0, 3), first, i == len - 1, 1'($urandom));
      end
      expect_result("rand", $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) gap_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
